key_event_encoder: RTL

Reader counterpart to the keystroke injector: watches the 73-bit keystroke array and turns key state changes into a queue of discrete key events (key index, press/release, shift state). It sits between the keyboard matrix source and any consumer that needs typed characters. Consumers include the key-logging and macro-record features and the on-screen-display capture. Scanning is serial, one key per clock-enable tick, with two-sample debounce and an output FIFO.

---
 rtl/key_event_encoder_pkg.sv | 23 ++
 rtl/key_event_encoder_if.sv | 23 ++
 rtl/key_event_encoder_fifo.sv | 88 ++++++++
 rtl/key_event_encoder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/key_event_encoder_pkg.sv
// Shared types and constants for the keystroke event encoder and its event FIFO.
package coco3_key_pkg;

  localparam int NUM_KEYS  = 73;
  localparam int KEY_SHIFT = 55;
  localparam int KEY_ENTER = 48;

  typedef struct packed {
    logic [6:0] code;
    logic       press;
    logic       shift;
  } key_evt_t;

  typedef enum logic {
    ST_PRIME,
    ST_SCAN
  } scan_state_t;

  function automatic logic [6:0] next_idx(input logic [6:0] idx, input logic [6:0] last);
    return (idx == last) ? 7'd0 : idx + 7'd1;
  endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// Event-side bundle of the keystroke event encoder: FIFO head, pop handshake and overflow flag.
interface key_event_encoder_if;

  logic       EVT_VALID;
  logic [6:0] EVT_CODE;
  logic       EVT_PRESS;
  logic       EVT_SHIFT;
  logic       EVT_READY;
  logic [3:0] FIFO_COUNT;
  logic       OVERFLOW;
  logic       OVF_CLR;

  modport master (
    output EVT_VALID, EVT_CODE, EVT_PRESS, EVT_SHIFT, FIFO_COUNT, OVERFLOW,
    input  EVT_READY, OVF_CLR
  );

  modport slave (
    input  EVT_VALID, EVT_CODE, EVT_PRESS, EVT_SHIFT, FIFO_COUNT, OVERFLOW,
    output EVT_READY, OVF_CLR
  );

endinterface

// File: rtl/key_event_encoder_fifo.sv
// Event queue with a registered head; a push reaches the head one falling edge later.
module key_evt_fifo
  import coco3_key_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  key_evt_t                   din_i,
  input  logic                       pop_i,
  output logic                       accept_o,
  output key_evt_t                   head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  key_evt_t               mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_q, wr_d;
  logic [PTR_W-1:0]       rd_q, rd_d;
  logic [PTR_W-1:0]       rd_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  key_evt_t               head_q, head_d;
  logic                   hv_q, hv_d;
  logic                   pop;
  logic                   push_acc;

  assign pop      = pop_i & hv_q;
  assign accept_o = (cnt_q < CNT_W'(DEPTH)) | pop;
  assign push_acc = push_i & accept_o;
  assign rd_nxt   = rd_q + PTR_W'(1);

  // The head register mirrors mem_q[rd_q]; on a pop it is refilled from the
  // following slot so a steady stream pops every cycle without a bubble.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q + CNT_W'(push_acc) - CNT_W'(pop);
    head_d = head_q;
    hv_d   = hv_q;
    if (push_acc) begin
      wr_d = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = rd_nxt;
      if (cnt_q >= CNT_W'(2)) begin
        head_d = mem_q[rd_nxt];
        hv_d   = 1'b1;
      end else begin
        head_d = '0;
        hv_d   = 1'b0;
      end
    end else if (!hv_q && (cnt_q != '0)) begin
      head_d = mem_q[rd_q];
      hv_d   = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (push_acc) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      hv_q   <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      hv_q   <= hv_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = hv_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/key_event_encoder.sv
// Serial keystroke scanner: two-sample debounce per key, press/release events queued with SHIFT state.
// KEY_EVT_RELEASE_EN: when defined, releases are queued too; otherwise they are absorbed silently.
module key_event_encoder
  import coco3_key_pkg::*;
#(
  parameter int NUM_KEYS   = 73,
  parameter int FIFO_DEPTH = 8,
  parameter int SHIFT_IDX  = 55
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                SCAN_EN,
  input  logic [NUM_KEYS-1:0] KEY_IN,
  key_event_encoder_if.master evt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  scan_state_t          state_q, state_d;
  logic [6:0]           idx_q, idx_d;
  logic [NUM_KEYS-1:0]  sample_q, sample_d;
  logic [NUM_KEYS-1:0]  committed_q, committed_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_set;
  logic                 push;
  logic                 accept;
  logic                 cur;
  logic                 cand;
  key_evt_t             push_evt;
  key_evt_t             head;
  logic                 head_vld;
  logic [CNT_W-1:0]     count;

  assign cur  = KEY_IN[idx_q];
  // A change is accepted only after the same level is seen on two consecutive passes.
  assign cand = (cur == sample_q[idx_q]) && (cur != committed_q[idx_q]);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    sample_d       = sample_q;
    committed_d    = committed_q;
    push           = 1'b0;
    ovf_set        = 1'b0;
    push_evt.code  = idx_q;
    push_evt.press = cur;
    push_evt.shift = committed_q[SHIFT_IDX];
    case (state_q)
      ST_PRIME: begin
        if (SCAN_EN) begin
          sample_d    = KEY_IN;
          committed_d = KEY_IN;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (SCAN_EN) begin
          sample_d[idx_q] = cur;
          idx_d           = next_idx(idx_q, 7'(NUM_KEYS - 1));
          if (cand) begin
`ifdef KEY_EVT_RELEASE_EN
            if (accept) begin
              push               = 1'b1;
              committed_d[idx_q] = cur;
            end else begin
              ovf_set = 1'b1;
            end
`else
            if (!cur) begin
              committed_d[idx_q] = 1'b0;
            end else if (accept) begin
              push               = 1'b1;
              committed_d[idx_q] = 1'b1;
            end else begin
              ovf_set = 1'b1;
            end
`endif
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase
    ovf_d = ovf_set | (ovf_q & ~evt.OVF_CLR);
  end

  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_PRIME;
      idx_q       <= '0;
      sample_q    <= '0;
      committed_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sample_q    <= sample_d;
      committed_q <= committed_d;
      ovf_q       <= ovf_d;
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .push_i   (push),
    .din_i    (push_evt),
    .pop_i    (evt.EVT_READY),
    .accept_o (accept),
    .head_o   (head),
    .valid_o  (head_vld),
    .count_o  (count)
  );

  assign evt.EVT_VALID  = head_vld;
  assign evt.EVT_CODE   = head.code;
  assign evt.EVT_SHIFT  = head.shift;
  assign evt.FIFO_COUNT = 4'(count);
  assign evt.OVERFLOW   = ovf_q;

`ifdef KEY_EVT_RELEASE_EN
  assign evt.EVT_PRESS = head.press;
`else
  logic unused_press;
  assign unused_press  = head.press;
  assign evt.EVT_PRESS = 1'b1;
`endif

endmodule
